l8mux_tdm: RTL and testbench

- Time-division 8-to-1 multiplexer; transmit end of the 3-select 1-to-8 demux tree (`l2demux`).
- Snapshots eight channel bits and sends them serially on `x`, one slot per channel.
- Drives matching select lines `s1`, `s2`, `s3` so a downstream demux routes each slot to its channel output `y8_1..y8_8`.
- Adds frame sequencing, a start/busy handshake, back-to-back frames and an optional parity slot.

---
 rtl/l8mux_tdm.sv | 162 ++++++++++++++++
 tb/tb_l8mux_tdm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/l8mux_tdm.sv
// l8mux_tdm: time-division 8-to-1 mux, transmit side of the l2demux tree.
// Snapshots d on start, serialises it one slot per channel on x with the
// matching {s1,s2,s3} select, HOLD_CYCLES clocks per slot.
// Optional parity slot: define L8MUX_PARITY_EN.
module l8mux_tdm #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       start,
  output logic       busy,
  output logic       x,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       x_valid,
  output logic       frame_done,
  output logic       par_slot
);

`ifdef L8MUX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state, nstate;
  logic [2:0]  slot, nslot;
  logic [3:0]  hold, nhold;
  logic [7:0]  shadow, nshadow;
  logic        frame_end;

  logic        n_x, n_valid, n_done;
  logic [2:0]  n_sel;
`ifdef L8MUX_PARITY_EN
  logic        n_par;
`endif

  // Sequencer next state: hold counter paces slots, end of frame may chain.
  always_comb begin
    nstate    = state;
    nslot     = slot;
    nhold     = hold;
    nshadow   = shadow;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nstate  = SEND;
          nslot   = 3'd0;
          nhold   = 4'd0;
          nshadow = d;
        end
      end
      SEND: begin
        if (hold != HOLD_LAST) begin
          nhold = hold + 4'd1;
        end else begin
          nhold = 4'd0;
          if (slot != 3'd7) begin
            nslot = slot + 3'd1;
          end else begin
`ifdef L8MUX_PARITY_EN
            nstate = PAR;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef L8MUX_PARITY_EN
      PAR: begin
        if (hold != HOLD_LAST) nhold = hold + 4'd1;
        else                   frame_end = 1'b1;
      end
`endif
      default: nstate = IDLE;
    endcase
    // Last cycle of a frame: start here chains the next frame with no gap.
    if (frame_end) begin
      nslot = 3'd0;
      nhold = 4'd0;
      if (start) begin
        nstate  = SEND;
        nshadow = d;
      end else begin
        nstate  = IDLE;
      end
    end
  end

  // Output values for the coming cycle, derived from the next state so
  // every output can be a plain register.
  always_comb begin
    n_x     = 1'b0;
    n_sel   = 3'd0;
    n_valid = 1'b0;
    n_done  = 1'b0;
`ifdef L8MUX_PARITY_EN
    n_par   = 1'b0;
`endif
    case (nstate)
      SEND: begin
        n_x     = nshadow[nslot];
        n_sel   = nslot;
        n_valid = 1'b1;
`ifndef L8MUX_PARITY_EN
        n_done  = (nslot == 3'd7) && (nhold == HOLD_LAST);
`endif
      end
`ifdef L8MUX_PARITY_EN
      PAR: begin
        n_x     = ^nshadow;
        n_sel   = 3'd7;
        n_valid = 1'b1;
        n_par   = 1'b1;
        n_done  = (nhold == HOLD_LAST);
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot       <= 3'd0;
      hold       <= 4'd0;
      shadow     <= 8'd0;
      busy       <= 1'b0;
      x          <= 1'b0;
      {s1,s2,s3} <= 3'd0;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      slot       <= nslot;
      hold       <= nhold;
      shadow     <= nshadow;
      busy       <= n_valid;
      x          <= n_x;
      {s1,s2,s3} <= n_sel;
      x_valid    <= n_valid;
      frame_done <= n_done;
    end
  end

`ifdef L8MUX_PARITY_EN
  // Parity slot flag, registered alongside the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_slot <= 1'b0;
    else        par_slot <= n_par;
  end
`else
  assign par_slot = 1'b0;
`endif

endmodule

// File: tb/tb_l8mux_tdm.sv
// tb_l8mux_tdm: directed bench for l8mux_tdm, one instance at H=1 and one
// at H=4. Output bundle: {busy,x_valid,frame_done,par_slot,x,s1,s2,s3}.
module tb_l8mux_tdm;

`ifdef L8MUX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] d1 = 8'd0, d4 = 8'd0;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       busy1, x1, a1, b1, c1, v1, fd1, p1;
  logic       busy4, x4, a4, b4, c4, v4, fd4, p4;
  logic [7:0] o1, o4;
  int         n_chk = 0, n_err = 0, done_cnt = 0;

  always #5 clk = ~clk;

  l8mux_tdm #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .start(start1), .busy(busy1), .x(x1),
    .s1(a1), .s2(b1), .s3(c1), .x_valid(v1), .frame_done(fd1), .par_slot(p1));
  l8mux_tdm #(.HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .start(start4), .busy(busy4), .x(x4),
    .s1(a4), .s2(b4), .s3(c4), .x_valid(v4), .frame_done(fd4), .par_slot(p4));

  assign o1 = {busy1, v1, fd1, p1, x1, a1, b1, c1};
  assign o4 = {busy4, v4, fd4, p4, x4, a4, b4, c4};

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic [7:0] dv, input logic st);
    if (which == 1) begin d1 = dv; start1 = st; end
    else            begin d4 = dv; start4 = st; end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " u1"}, o1, 8'h00);
    chk({tag, " u4"}, o4, 8'h00);
  endtask

  // Expected bundle for cycle c of a frame carrying dv at hold h.
  function automatic logic [7:0] exp_out(input logic [7:0] dv, input int h, input int c);
    int sl;
    logic xb, ps;
    logic [2:0] sel;
    sl = c / h;
    if (sl < 8) begin xb = dv[sl]; sel = sl[2:0]; ps = 1'b0; end
    else        begin xb = ^dv;    sel = 3'd7;    ps = 1'b1; end
    return {1'b1, 1'b1, (c == FL*h - 1), ps, xb, sel};
  endfunction

  // Checks one frame from slot 0 onward. d is flipped right after the
  // snapshot and start is pulsed mid-frame; neither may disturb the frame.
  task automatic run_frame(input int which, input logic [7:0] dv, input string tag,
                           input logic cont, input logic [7:0] nd);
    int h, n;
    logic [7:0] act;
    h = (which == 1) ? 1 : 4;
    n = FL * h;
    for (int c = 0; c < n; c++) begin
      act = (which == 1) ? o1 : o4;
      chk($sformatf("%s c%0d", tag, c), act, exp_out(dv, h, c));
      if (act[5]) done_cnt++;
      if (c == n - 1)  drive(which, nd, cont);
      else if (c == 2) drive(which, ~dv, 1'b1);
      else             drive(which, ~dv, 1'b0);
      tick();
    end
  endtask

  bit xs [8] = '{0, 1, 1, 0, 0, 1, 0, 1};

  initial begin
    // Reset held 3 cycles, then 20 idle cycles with start low.
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_async");
    repeat (3) @(posedge clk);
    #1 chk_idle("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    // Single H=1 frame against hand-written x sequence.
    drive(1, 8'b1010_0110, 1'b1);
    tick();
    drive(1, 8'b1010_0110, 1'b0);
    for (int k = 0; k < FL; k++) begin
      if (k < 8) chk($sformatf("single s%0d", k), o1[3:0], {xs[k], 3'(k)});
      chk($sformatf("single vld%0d", k), {6'd0, o1[7:6]}, 8'd3);
      chk($sformatf("single done%0d", k), {7'd0, o1[5]}, {7'd0, k == FL-1});
      tick();
    end
    chk_idle("single_after");

    // Snapshot isolation, H=4: d changes to 0F after the start edge.
    drive(4, 8'hF0, 1'b1);
    tick();
    run_frame(4, 8'hF0, "snap", 1'b0, 8'h00);
    chk_idle("snap_after");

    // Three back-to-back frames on H=1.
    done_cnt = 0;
    drive(1, 8'h55, 1'b1);
    tick();
    run_frame(1, 8'h55, "b2b0", 1'b1, 8'hAA);
    run_frame(1, 8'hAA, "b2b1", 1'b1, 8'hFF);
    run_frame(1, 8'hFF, "b2b2", 1'b0, 8'h00);
    chk("b2b_done_cnt", 8'(done_cnt), 8'd3);
    chk_idle("b2b_after");

    // Parity-weighted pattern on H=4.
    drive(4, 8'b0000_0111, 1'b1);
    tick();
    run_frame(4, 8'b0000_0111, "par", 1'b0, 8'h00);
    chk_idle("par_after");

    // Reset during slot 3 of an H=4 frame.
    drive(4, 8'hFF, 1'b1);
    tick();
    drive(4, 8'hFF, 1'b0);
    repeat (13) tick();
    chk("mid_slot3", o4, exp_out(8'hFF, 4, 13));
    #1 rst_n = 1'b0;
    #1 chk_idle("mid_rst_async");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("mid_rst_idle%0d", i));
    end
    drive(4, 8'hA5, 1'b1);
    tick();
    run_frame(4, 8'hA5, "post_rst", 1'b0, 8'h00);
    chk_idle("post_rst_after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
